snitch_clint_ctrl: RTL and testbench
====================================

// Module: snitch_clint_ctrl
// PURPOSE
// - Core-local interruptor (CLINT) for the Snitch cluster. It is a synthesizable replacement for the
//   DPI-based tick model that drives the cluster's msip_i/mtip_i pins in the testharness.
// - Holds one software-interrupt bit and one 64-bit timer compare per hart. Shares one 64-bit mtime
//   counter across all harts.
// - Programmed through a 32-bit register port with valid/ready handshake. Sits between the narrow
//   out-port decode and the cluster's interrupt inputs.
// PARAMETERS
// - NrCores      9     number of harts; width of msip_o/mtip_o
// - AddrWidth    16    register-port offset width (byte address)
// - PrescaleDiv  1     clk_i cycles per mtime increment; must be >=1 (1 = every cycle)
// PORTS
// - clk_i        in   1             clock; single domain
// - rst_ni       in   1             asynchronous reset, active-low
// - req_valid_i  in   1             register request valid
// - req_ready_o  out  1             register request ready
// - req_write_i  in   1             1 = write, 0 = read
// - req_addr_i   in   AddrWidth     byte offset, 4-byte aligned
// - req_wdata_i  in   32            write data
// - req_wstrb_i  in   4             byte enables for writes
// - rsp_valid_o  out  1             response valid
// - rsp_ready_i  in   1             response accepted
// - rsp_rdata_o  out  32            read data (0 on writes and on errors)
// - rsp_error_o  out  1             access to an unmapped offset, or to a hart >= NrCores
// - msip_o       out  NrCores       software interrupt per hart
// - mtip_o       out  NrCores       timer interrupt per hart
// BEHAVIOUR
// - Address map:
//   - MSIP[h]          at 0x0000+4h. Only bit0 is storage; bits 31:1 read 0.
//   - MTIMECMP[h] lo   at 0x4000+8h; hi at 0x4004+8h.
//   - MTIME lo         at 0xBFF8; hi at 0xBFFC.
//   - Any misaligned offset (addr[1:0]!=0) is an error.
// - Reset state:
//   - msip=0, mtimecmp=all-ones, mtime=0, prescaler=0, mtip_o=0.
//   - rsp_valid_o=0, rsp_error_o=0, rsp_rdata_o=0.
//   - req_ready_o=1 once reset is released.
// - Handshake:
//   - At most one transaction outstanding; req_ready_o = !rsp_valid_o || rsp_ready_i.
//   - A request is accepted on req_valid_i && req_ready_o.
//   - rsp_valid_o rises exactly 1 cycle after acceptance and holds until rsp_ready_i.
//   - rsp_rdata_o/rsp_error_o stay stable while rsp_valid_o is high.
//   - Back-to-back transactions at full throughput when rsp_ready_i is held at 1.
// - Writes:
//   - Applied at the acceptance edge, byte-wise per req_wstrb_i; visible from the next cycle.
//   - Errored writes have no side effect.
//   - Read data is sampled at the acceptance edge, i.e. the pre-write value of the same cycle.
// - Timer:
//   - The prescaler counts 0..PrescaleDiv-1. On the wrap cycle, mtime <= mtime+1, with 64-bit
//     wrap-around (all-ones -> 0).
//   - A software write to either half of MTIME in the same cycle as a tick wins: the written half
//     takes the wdata, the other half keeps its old value (no carry).
//   - Writing MTIME does not reset the prescaler.
// - Outputs:
//   - msip_o[h] is the MSIP[h] register directly (asserts 1 cycle after the write edge).
//   - mtip_o[h] is a registered (mtime >= mtimecmp[h]), unsigned 64-bit compare, 1 cycle behind
//     the register values. It is level-sensitive: it clears 1 cycle after mtimecmp is raised above
//     mtime.
// - Reset mid-transaction drops the pending response. No response is produced after reset release.
// STRUCTURE
// - snitch_clint_pkg:
//   - offset constants MsipBase, MtimecmpBase, MtimeLo, MtimeHi.
//   - clint_req_t/clint_rsp_t structs for the register port.
//   - function hart_idx(addr).
// - Sub-module snitch_clint_timer: prescaler and 64-bit mtime with split lo/hi write ports and a
//   tick output.
// - Top level: decode, per-hart register array, compare, response register.
// TESTING
// - Reset, then read 0xBFF8 at once -> rdata=0 or 1, error=0. All msip_o/mtip_o stay 0 for 100 cycles.
// - Write 0x0000_0001 to 0x0008 (hart 2) -> msip_o=0x004 on the cycle after acceptance.
//   Write 0 -> msip_o=0 the cycle after.
// - PrescaleDiv=4: write MTIMECMP[0]={0,40}, MTIME={0,0} -> mtip_o[0] rises exactly 161 cycles
//   after the MTIME-write edge. Write MTIMECMP[0] hi=1 -> mtip_o[0] clears 1 cycle later.
// - MTIME lo=0xFFFF_FFFF and hi=0xFFFF_FFFF, PrescaleDiv=1 -> next read of lo returns a small
//   value, hi=0 (wrap).
// - Read 0x0000+4*NrCores and 0x1002 -> error=1, rdata=0. Write to either -> error=1, no state change.
// - Hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0 and response stable.
//   Release -> next request accepted in the same cycle.
//   Randomized stall test against the reference model: no lost or duplicated responses.

Source files
------------

// File: rtl/snitch_clint_pkg.sv
`default_nettype none
// ============================================================================
// snitch_clint_pkg -- CLINT offset map, register-port structs and helpers
// Revision: 1.0
// ============================================================================
package snitch_clint_pkg;

   localparam logic [31:0] MsipBase     = 32'h0000_0000;
   localparam logic [31:0] MtimecmpBase = 32'h0000_4000;
   localparam logic [31:0] MtimeLo      = 32'h0000_BFF8;
   localparam logic [31:0] MtimeHi      = 32'h0000_BFFC;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } clint_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
   } clint_rsp_t;

   // MSIP entries are 4 bytes apart, MTIMECMP entries 8 bytes apart.
   function automatic logic [31:0] hart_idx(input logic [31:0] addr);
      if (addr >= MtimecmpBase) begin
         return (addr - MtimecmpBase) >> 3;
      end
      return (addr - MsipBase) >> 2;
   endfunction

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) begin
            res[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snitch_clint_timer.sv
`default_nettype none
// ============================================================================
// snitch_clint_timer -- prescaler plus shared 64-bit mtime with split lo/hi writes
// Revision: 1.0
// ============================================================================
module snitch_clint_timer
   import snitch_clint_pkg::*;
#(
   parameter int unsigned PrescaleDiv = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lo_we_i,
   input  logic        hi_we_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   output logic        tick_o,
   output logic [63:0] mtime_o
);

   localparam int unsigned PsWidth = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
   localparam logic [PsWidth-1:0] PsMax = PsWidth'(PrescaleDiv - 1);

   logic [PsWidth-1:0] ps_q, ps_d;
   logic [63:0]        mtime_q, mtime_d;

   assign tick_o  = (ps_q == PsMax);
   assign mtime_o = mtime_q;

   // A software write beats the tick; the unwritten half keeps its old value, no carry.
   always_comb begin
      ps_d    = tick_o ? '0 : ps_q + PsWidth'(1);
      mtime_d = tick_o ? mtime_q + 64'd1 : mtime_q;
      if (lo_we_i || hi_we_i) begin
         mtime_d = mtime_q;
      end
      if (lo_we_i) begin
         mtime_d[31:0] = strb_merge(mtime_q[31:0], wdata_i, wstrb_i);
      end
      if (hi_we_i) begin
         mtime_d[63:32] = strb_merge(mtime_q[63:32], wdata_i, wstrb_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ps_q    <= '0;
         mtime_q <= '0;
      end else begin
         ps_q    <= ps_d;
         mtime_q <= mtime_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/snitch_clint_ctrl.sv
`default_nettype none
// ============================================================================
// snitch_clint_ctrl -- CLINT: register decode, per-hart MSIP/MTIMECMP, mtip compare
// Revision: 1.0
// ============================================================================
module snitch_clint_ctrl
   import snitch_clint_pkg::*;
#(
   parameter int unsigned NrCores     = 9,
   parameter int unsigned AddrWidth   = 16,
   parameter int unsigned PrescaleDiv = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_write_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [31:0]          req_wdata_i,
   input  logic [3:0]           req_wstrb_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_error_o,
   output logic [NrCores-1:0]   msip_o,
   output logic [NrCores-1:0]   mtip_o
);

   localparam logic [31:0] CmpEnd = MtimecmpBase + 32'(NrCores * 8);

   clint_req_t         req;
   clint_rsp_t         rsp_d, rsp_q;
   logic               rsp_valid_q;
   logic [31:0]        hart;
   logic               aligned, is_msip, is_cmp, cmp_hi, is_lo, is_hi;
   logic               err, accept, wr_en;
   logic [31:0]        rdata;
   logic [NrCores-1:0] msip_d, msip_q, mtip_d, mtip_q;
   logic [63:0]        mtimecmp_d [NrCores];
   logic [63:0]        mtimecmp_q [NrCores];
   logic [63:0]        mtime;
   logic               tick_unused;

   assign req = '{write: req_write_i, addr: 32'(req_addr_i),
                  wdata: req_wdata_i, wstrb: req_wstrb_i};

   assign hart    = hart_idx(req.addr);
   assign aligned = (req.addr[1:0] == 2'b00);
   assign is_msip = (req.addr < MtimecmpBase) && (hart < 32'(NrCores));
   assign is_cmp  = (req.addr >= MtimecmpBase) && (req.addr < CmpEnd);
   assign cmp_hi  = req.addr[2];
   assign is_lo   = (req.addr == MtimeLo);
   assign is_hi   = (req.addr == MtimeHi);
   assign err     = !aligned || !(is_msip || is_cmp || is_lo || is_hi);

   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = req_valid_i && req_ready_o;
   assign wr_en       = accept && req.write && !err;

   snitch_clint_timer #(
      .PrescaleDiv (PrescaleDiv)
   ) i_timer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .lo_we_i (wr_en && is_lo),
      .hi_we_i (wr_en && is_hi),
      .wdata_i (req.wdata),
      .wstrb_i (req.wstrb),
      .tick_o  (tick_unused),
      .mtime_o (mtime)
   );

   // Read data reflects register state before any write in the same cycle.
   always_comb begin
      rdata = '0;
      for (int h = 0; h < NrCores; h++) begin
         if (hart == 32'(h)) begin
            if (is_msip) begin
               rdata = {31'b0, msip_q[h]};
            end
            if (is_cmp) begin
               rdata = cmp_hi ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
            end
         end
      end
      if (is_lo) begin
         rdata = mtime[31:0];
      end
      if (is_hi) begin
         rdata = mtime[63:32];
      end
   end

   always_comb begin
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      for (int h = 0; h < NrCores; h++) begin
         if (wr_en && hart == 32'(h)) begin
            if (is_msip && req.wstrb[0]) begin
               msip_d[h] = req.wdata[0];
            end
            if (is_cmp && cmp_hi) begin
               mtimecmp_d[h][63:32] = strb_merge(mtimecmp_q[h][63:32], req.wdata, req.wstrb);
            end
            if (is_cmp && !cmp_hi) begin
               mtimecmp_d[h][31:0] = strb_merge(mtimecmp_q[h][31:0], req.wdata, req.wstrb);
            end
         end
      end
   end

   for (genvar h = 0; h < NrCores; h++) begin : g_mtip
      assign mtip_d[h] = (mtime >= mtimecmp_q[h]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         msip_q <= '0;
         mtip_q <= '0;
         for (int h = 0; h < NrCores; h++) begin
            mtimecmp_q[h] <= '1;
         end
      end else begin
         msip_q     <= msip_d;
         mtip_q     <= mtip_d;
         mtimecmp_q <= mtimecmp_d;
      end
   end

   assign rsp_d = '{rdata: (req.write || err) ? 32'h0 : rdata, error: err};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_q       <= rsp_d;
      end else if (rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_q.rdata;
   assign rsp_error_o = rsp_q.error;
   assign msip_o      = msip_q;
   assign mtip_o      = mtip_q;

endmodule
`default_nettype wire

// File: tb/tb_snitch_clint_ctrl.sv
`default_nettype none
// ============================================================================
// tb_snitch_clint_ctrl -- directed and random checks against a behavioural CLINT model
// Revision: 1.0
// ============================================================================
module tb_snitch_clint_ctrl;

   localparam int N   = 9;
   localparam int DIV = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_write, rsp_ready;
   logic [15:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_wstrb;
   wire           req_ready, rsp_valid, rsp_error;
   wire  [31:0]   rsp_rdata;
   wire  [N-1:0]  msip, mtip;

   snitch_clint_ctrl #(
      .NrCores     (N),
      .AddrWidth   (16),
      .PrescaleDiv (DIV)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_wstrb_i (req_wstrb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_error_o (rsp_error),
      .msip_o      (msip),
      .mtip_o      (mtip)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [N-1:0] m_msip, m_mtip;
   logic [63:0]  m_cmp [N];
   logic [63:0]  m_mtime;
   int           m_ps;
   bit           m_rvalid, m_err, m_acc;
   logic [31:0]  m_rdata;
   int           n_acc, n_hs, cyc;
   int           n_checks = 0, n_fail = 0;

   logic [31:0]  rd;
   logic         er;
   logic         irq_seen;
   int           c_e;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // kind: 0 = unmapped/misaligned, 1 = MSIP, 2 = MTIMECMP, 3 = MTIME
   function automatic void classify(input logic [15:0] addr, output int kind,
                                    output int h, output bit hi);
      int a;
      a = int'(addr);
      kind = 0; h = 0; hi = 0;
      if (a % 4 != 0) return;
      if (a < 4 * N) begin
         kind = 1; h = a / 4;
      end else if (a >= 'h4000 && a < 'h4000 + 8 * N) begin
         kind = 2; h = (a - 'h4000) / 8; hi = ((a - 'h4000) % 8) == 4;
      end else if (a == 'hBFF8) begin
         kind = 3;
      end else if (a == 'hBFFC) begin
         kind = 3; hi = 1;
      end
   endfunction

   task automatic model_update();
      bit          tick, acc, hi;
      int          kind, h;
      logic [N-1:0] mt;
      logic [63:0] nt;
      logic [31:0] mask;
      if (!rst_n) begin
         m_msip = '0; m_mtip = '0; m_mtime = '0; m_ps = 0;
         m_rvalid = 0; m_err = 0; m_rdata = '0; m_acc = 0;
         for (int k = 0; k < N; k++) m_cmp[k] = '1;
         return;
      end
      tick = (m_ps == DIV - 1);
      for (int k = 0; k < N; k++) mt[k] = (m_mtime >= m_cmp[k]);
      acc = req_valid && (!m_rvalid || rsp_ready);
      classify(req_addr, kind, h, hi);
      nt = tick ? m_mtime + 64'd1 : m_mtime;
      mask = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
      if (acc) begin
         n_acc++;
         m_rvalid = 1;
         m_err    = (kind == 0);
         m_rdata  = '0;
         if (!req_write) begin
            case (kind)
               1: m_rdata = {31'b0, m_msip[h]};
               2: m_rdata = hi ? m_cmp[h][63:32] : m_cmp[h][31:0];
               3: m_rdata = hi ? m_mtime[63:32] : m_mtime[31:0];
               default: m_rdata = '0;
            endcase
         end else begin
            case (kind)
               1: if (req_wstrb[0]) m_msip[h] = req_wdata[0];
               2: if (hi) m_cmp[h][63:32] = (m_cmp[h][63:32] & ~mask) | (req_wdata & mask);
                  else    m_cmp[h][31:0]  = (m_cmp[h][31:0]  & ~mask) | (req_wdata & mask);
               3: begin
                  nt = m_mtime;
                  if (hi) nt[63:32] = (m_mtime[63:32] & ~mask) | (req_wdata & mask);
                  else    nt[31:0]  = (m_mtime[31:0]  & ~mask) | (req_wdata & mask);
               end
               default: ;
            endcase
         end
      end else if (rsp_ready) begin
         m_rvalid = 0;
      end
      m_mtime = nt;
      m_ps    = tick ? 0 : m_ps + 1;
      m_mtip  = mt;
      m_acc   = acc;
   endtask

   task automatic check_outputs();
      check("req_ready", req_ready, !m_rvalid || rsp_ready);
      check("rsp_valid", rsp_valid, m_rvalid);
      if (m_rvalid) begin
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_error", rsp_error, m_err);
      end
      check("msip", msip, m_msip);
      check("mtip", mtip, m_mtip);
   endtask

   // One clock: count handshakes, advance the model at the edge, check at the falling edge.
   task automatic step();
      if (rst_n && rsp_valid && rsp_ready) n_hs++;
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic set_req(input bit v, input bit w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
   endtask

   // Returns at the falling edge after acceptance, with the response on the port.
   task automatic txn(input bit w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output logic e);
      set_req(1, w, a, d, s);
      for (int i = 0; i < 50; i++) begin
         step();
         if (m_acc) break;
      end
      if (!m_acc) check("txn_timeout", 0, 1);
      r = rsp_rdata;
      e = rsp_error;
      req_valid = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_acc = 0; n_hs = 0; cyc = 0;
      rst_n = 0; rsp_ready = 0;
      set_req(0, 0, 16'h0, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) step();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_error", rsp_error, 0);
      check("rst_msip", msip, 0);
      check("rst_mtip", mtip, 0);
      rst_n = 1;
      rsp_ready = 1;

      // mtime read straight out of reset
      txn(0, 16'hBFF8, 0, 4'h0, rd, er);
      check("rst_mtime_lo_small", rd <= 32'd1, 1);
      check("rst_mtime_err", er, 0);

      irq_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         irq_seen = irq_seen | (|{msip, mtip});
      end
      check("idle_irq", irq_seen, 0);

      // Software interrupt for hart 2
      txn(1, 16'h0008, 32'h1, 4'hF, rd, er);
      check("msip_set", msip, 9'h004);
      txn(1, 16'h0008, 32'h0, 4'hF, rd, er);
      check("msip_clr", msip, 9'h000);

      // Timer: align the MTIME lo write with a prescaler wrap edge
      txn(1, 16'hBFFC, 32'h0, 4'hF, rd, er);
      for (int i = 0; i < 2 * DIV && m_ps != DIV - 1; i++) step();
      txn(1, 16'hBFF8, 32'h0, 4'hF, rd, er);
      c_e = cyc;
      txn(1, 16'h4000, 32'd40, 4'hF, rd, er);
      txn(1, 16'h4004, 32'd0, 4'hF, rd, er);
      for (int i = 0; i < 400 && !mtip[0]; i++) step();
      check("mtip_latency", cyc - c_e, 161);
      txn(1, 16'h4004, 32'd1, 4'hF, rd, er);
      check("mtip_hold", mtip[0], 1);
      step();
      check("mtip_clear", mtip[0], 0);

      // 64-bit wrap
      txn(1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, er);
      txn(1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er);
      for (int i = 0; i < 2 * DIV; i++) step();
      txn(0, 16'hBFF8, 0, 4'h0, rd, er);
      check("wrap_lo_small", rd < 32'd16, 1);
      txn(0, 16'hBFFC, 0, 4'h0, rd, er);
      check("wrap_hi", rd, 0);

      // Error accesses
      txn(0, 16'h0024, 0, 4'h0, rd, er);
      check("err_msipN_err", er, 1);
      check("err_msipN_rdata", rd, 0);
      txn(0, 16'h1002, 0, 4'h0, rd, er);
      check("err_mis_err", er, 1);
      check("err_mis_rdata", rd, 0);
      txn(1, 16'h0024, 32'hFFFF_FFFF, 4'hF, rd, er);
      check("err_wr_msipN", er, 1);
      txn(1, 16'h1002, 32'hFFFF_FFFF, 4'hF, rd, er);
      check("err_wr_mis", er, 1);
      txn(1, 16'h0002, 32'hFFFF_FFFF, 4'hF, rd, er);
      check("err_wr_mis0", er, 1);
      step();
      check("err_no_msip", msip, 0);

      // Back-pressure
      rsp_ready = 0;
      txn(0, 16'h4000, 0, 4'h0, rd, er);
      set_req(1, 0, 16'h4004, 0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_ready", req_ready, 0);
         check("stall_valid", rsp_valid, 1);
         check("stall_rdata", rsp_rdata, 40);
      end
      rsp_ready = 1;
      #1;
      check("release_ready", req_ready, 1);
      step();
      check("release_valid", rsp_valid, 1);
      check("release_rdata", rsp_rdata, 1);
      req_valid = 0;

      // Random traffic with random back-pressure
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] a;
         rsp_ready = ($urandom_range(0, 9) < 7);
         if (!req_valid || m_acc) begin
            case ($urandom_range(0, 5))
               0:       a = 16'(4 * $urandom_range(0, N));
               1, 2:    a = 16'('h4000 + 8 * $urandom_range(0, N - 1) + 4 * $urandom_range(0, 1));
               3:       a = $urandom_range(0, 1) ? 16'hBFF8 : 16'hBFFC;
               4:       a = 16'($urandom_range(0, 15));
               default: a = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) < 6)
               set_req(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            else
               req_valid = 0;
         end
         step();
      end
      req_valid = 0;
      rsp_ready = 1;
      for (int i = 0; i < 4; i++) step();
      check("resp_count", n_hs, n_acc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
